// File: rtl/sseg_scan_mux_n.sv
// N-digit time-multiplexed seven-segment driver with frame-synchronous shadowing,
// per-digit decimal points and live leading-zero blanking. Define SSEG_DIM_EN for brightness PWM.
module sseg_scan_mux_n #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
`ifdef SSEG_DIM_EN
  input  logic [3:0]              brightness,
`endif
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              sseg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] PRE_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           r_pre_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow_data;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic                    r_primed;

  logic                    w_slot_end;
  logic                    w_load;
  logic [3:0]              w_nib;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic                    w_zero_run;
  logic [NUM_DIGITS-1:0]   w_an_sel;
  logic                    w_blank;
  logic                    w_on;

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 7'b1000000;
      4'h1: hex_seg = 7'b1111001;
      4'h2: hex_seg = 7'b0100100;
      4'h3: hex_seg = 7'b0110000;
      4'h4: hex_seg = 7'b0011001;
      4'h5: hex_seg = 7'b0010010;
      4'h6: hex_seg = 7'b0000010;
      4'h7: hex_seg = 7'b1111000;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0010000;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b0000011;
      4'hC: hex_seg = 7'b1000110;
      4'hD: hex_seg = 7'b0100001;
      4'hE: hex_seg = 7'b0000110;
      default: hex_seg = 7'b0001110;
    endcase
  endfunction

  assign w_slot_end = (r_pre_cnt == PRE_MAX);
  // Reload on the very first edge after reset and at the last cycle of every frame.
  assign w_load     = !r_primed || (w_slot_end && (r_idx == IDX_MAX));
  assign w_nib      = r_shadow_data[{r_idx, 2'b00} +: 4];
  assign w_blank    = blank_lz && w_lz[r_idx];

  // w_lz[i] is set when digits NUM_DIGITS-1..i are all zero; digit 0 never blanks.
  always_comb begin
    w_lz       = '0;
    w_zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run && (r_shadow_data[4*i +: 4] == 4'h0);
      w_lz[i]    = w_zero_run;
    end
  end

  always_comb begin
    w_an_sel = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) w_an_sel[i] = 1'b0;
    end
  end

`ifdef SSEG_DIM_EN
  localparam int PW = $clog2(REFRESH_DIV + 1) + 6;
  logic [PW-1:0] w_duty_pos;
  logic [PW-1:0] w_duty_lim;
  assign w_duty_pos = PW'(r_pre_cnt) << 4;
  assign w_duty_lim = (PW'(brightness) + PW'(1)) * PW'(REFRESH_DIV);
  assign w_on       = (w_duty_pos < w_duty_lim);
`else
  assign w_on = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre_cnt     <= '0;
      r_idx         <= '0;
      r_shadow_data <= '0;
      r_shadow_dp   <= '0;
      r_primed      <= 1'b0;
      an            <= '1;
      sseg          <= 7'b1111111;
      dp            <= 1'b1;
      frame_tick    <= 1'b0;
    end else begin
      r_pre_cnt <= w_slot_end ? '0 : r_pre_cnt + 1'b1;
      if (w_slot_end) r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
      if (w_load) begin
        r_shadow_data <= data;
        r_shadow_dp   <= dp_in;
      end
      r_primed   <= 1'b1;
      frame_tick <= w_load;
      an         <= w_on ? w_an_sel : '1;
      sseg       <= w_blank ? 7'b1111111 : hex_seg(w_nib);
      dp         <= ~r_shadow_dp[r_idx];
    end
  end

endmodule

// File: tb/tb_sseg_scan_mux_n.sv
// Scoreboard bench for sseg_scan_mux_n: directed scenarios then random traffic,
// expected outputs derived from elapsed cycles since reset and a modelled shadow.
module tb_sseg_scan_mux_n;
  localparam int N = 4;
  localparam int R = 4;
  localparam int W = N + 9;

  logic           clk = 1'b0;
  logic           reset;
  logic [4*N-1:0] data;
  logic [N-1:0]   dp_in;
  logic           blank_lz;
  logic [N-1:0]   an;
  logic [6:0]     sseg;
  logic           dp;
  logic           frame_tick;
`ifdef SSEG_DIM_EN
  logic [3:0]     brightness = 4'd15;
`endif

  sseg_scan_mux_n #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
    .clk(clk), .reset(reset), .data(data), .dp_in(dp_in), .blank_lz(blank_lz),
`ifdef SSEG_DIM_EN
    .brightness(brightness),
`endif
    .an(an), .sseg(sseg), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference state: edges since reset release and the frame's latched inputs.
  int             mc = 0;
  logic [4*N-1:0] m_sd = '0;
  logic [N-1:0]   m_sp = '0;

  function automatic logic [W-1:0] model_out(input int c, input logic [4*N-1:0] sd,
                                             input logic [N-1:0] sp, input logic blz,
                                             input logic ld);
    int             d;
    logic [4*N-1:0] up;
    logic [N-1:0]   a;
    logic [6:0]     s;
    d    = (c / R) % N;
    up   = sd >> (4 * d);
    a    = '1;
    a[d] = 1'b0;
    s    = (blz && d != 0 && up == '0) ? 7'b1111111 : seg_tab[up[3:0]];
    return {a, s, ~sp[d], ld};
  endfunction

  task automatic step(input logic rst, input logic [4*N-1:0] d, input logic [N-1:0] p,
                      input logic blz);
    logic ld;
    @(negedge clk);
    reset    = rst;
    data     = d;
    dp_in    = p;
    blank_lz = blz;
    if (rst) begin
      exp_q.push_back({{N{1'b1}}, 7'b1111111, 1'b1, 1'b0});
      mc   = 0;
      m_sd = '0;
      m_sp = '0;
    end else begin
      ld = (mc == 0) || (mc % (R * N) == R * N - 1);
      exp_q.push_back(model_out(mc, m_sd, m_sp, blz, ld));
      if (ld) begin
        m_sd = d;
        m_sp = p;
      end
      mc++;
    end
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    logic [W-1:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {an, sseg, dp, frame_tick};
        n_checks++;
        if (got === e) n_pass++;
        else $display("FAIL out_chk t=%0t got an=%b sseg=%b dp=%b ft=%b want an=%b sseg=%b dp=%b ft=%b",
                      $time, got[W-1 -: N], got[8:2], got[1], got[0],
                      e[W-1 -: N], e[8:2], e[1], e[0]);
      end
    end
  end

  initial begin
    logic [4*N-1:0] rd;
    logic [N-1:0]   rp;
    logic           rb;
    reset = 1'b1; data = 16'hC840; dp_in = '0; blank_lz = 1'b0;

    repeat (3) step(1'b1, 16'hC840, 4'b0000, 1'b0);
    repeat (40) step(1'b0, 16'hC840, 4'b0000, 1'b0);
    // Move into the digit-1 slot, then change data mid-frame.
    for (int i = 0; i < 16 && (mc % 16) != 5; i++) step(1'b0, 16'hC840, 4'b0000, 1'b0);
    repeat (40) step(1'b0, 16'hD951, 4'b0000, 1'b0);

    repeat (34) step(1'b0, 16'h0050, 4'b0000, 1'b1);
    repeat (34) step(1'b0, 16'h0000, 4'b0000, 1'b1);
    repeat (34) step(1'b0, 16'h1234, 4'b0100, 1'b0);

    for (int i = 0; i < 16 && (mc % 4) != 2; i++) step(1'b0, 16'h1234, 4'b0100, 1'b0);
    step(1'b1, 16'h1234, 4'b0100, 1'b0);
    repeat (20) step(1'b0, 16'h1234, 4'b0100, 1'b0);

    rd = 16'hA0F3; rp = 4'b1001; rb = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        rd = 16'($urandom());
        if ($urandom_range(0, 2) == 0) rd[15:8] = 8'h00;
        rp = 4'($urandom());
      end
      if ($urandom_range(0, 19) == 0) rb = ~rb;
      step($urandom_range(0, 149) == 0, rd, rp, rb);
    end

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain_chk pending=%0d want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
